// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding, default widths and a constant-safe clog2 for the SNN blocks.
//   ST_INTEG / ST_REFRACT : neuron state encoding
//   DEF_*                 : default parameter values for lif_neuron_param
//   clog2(n)              : ceil(log2(n)), returns 0 for n <= 1
package snn_pkg;
   typedef enum logic {ST_INTEG = 1'b0, ST_REFRACT = 1'b1} state_t;
   localparam int DEF_N_IN  = 3;
   localparam int DEF_V_W   = 5;
   localparam int DEF_W_W   = 4;
   localparam int DEF_CNT_W = 16;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/snn_weighted_sum.sv
// snn_weighted_sum: combinational masked signed sum of the synaptic weights whose spike is set.
//   spike_in : N_IN spike mask, bit i selects weight i
//   w        : N_IN packed signed weights, weight i at [i*W_W +: W_W]
//   sum      : signed sum, wide enough for N_IN weights of any sign
import snn_pkg::*;
module snn_weighted_sum #(
   parameter int N_IN = DEF_N_IN,
   parameter int W_W  = DEF_W_W,
   parameter int SW   = W_W + clog2(N_IN) + 1
) (
   input  logic [N_IN-1:0]     spike_in,
   input  logic [N_IN*W_W-1:0] w,
   output logic signed [SW-1:0] sum
);
   always_comb begin
      sum = '0;
      for (int i = 0; i < N_IN; i++)
         if (spike_in[i]) sum = sum + SW'($signed(w[i*W_W +: W_W]));
   end
endmodule

// File: rtl/lif_neuron_param.sv
// lif_neuron_param: parametrised leaky integrate-and-fire neuron with weight bank, refractory period and spike counter.
//   clk, resetn           : clock, asynchronous active-low reset
//   en                    : 1 = neuron advances, 0 = neuron frozen (weights and cnt_clr still act)
//   spike_in              : incoming spikes, bit i drives synapse i
//   cfg_thresh/rest/leak  : firing threshold, rest potential / lower clamp, per-cycle leak
//   w_we, w_addr, w_data  : weight bank write port (out-of-range addresses ignored)
//   cnt_clr               : synchronous clear of spike_cnt, wins over a same-edge spike
//   spike_out             : registered one-cycle spike pulse
//   v_mem                 : registered membrane potential
//   refract               : high while the neuron is refractory
//   spike_cnt             : saturating spike count
import snn_pkg::*;
module lif_neuron_param #(
   parameter int N_IN        = DEF_N_IN,
   parameter int V_W         = DEF_V_W,
   parameter int W_W         = DEF_W_W,
   parameter int W_INIT      = 1,
   parameter int REFRACT_CYC = 0,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic [N_IN-1:0]  spike_in,
   input  logic [V_W-1:0]   cfg_thresh,
   input  logic [V_W-1:0]   cfg_rest,
   input  logic [V_W-1:0]   cfg_leak,
   input  logic             w_we,
   input  logic [(clog2(N_IN) > 0 ? clog2(N_IN) : 1)-1:0] w_addr,
   input  logic [W_W-1:0]   w_data,
   input  logic             cnt_clr,
   output logic             spike_out,
   output logic [V_W-1:0]   v_mem,
   output logic             refract,
   output logic [CNT_W-1:0] spike_cnt
);
   localparam int LG = clog2(N_IN);
   localparam int SW = W_W + LG + 1;
   localparam int VW = V_W + W_W + LG + 2;
   localparam int RW = clog2(REFRACT_CYC + 1) > 0 ? clog2(REFRACT_CYC + 1) : 1;

   logic [W_W-1:0]      w [N_IN];
   logic [N_IN*W_W-1:0] w_flat;
   logic signed [SW-1:0] sum;
   logic signed [VW-1:0] vn, th_s, rest_s;
   state_t               state, state_nx;
   logic [V_W-1:0]       v_nx;
   logic                 spk_nx;
   logic [RW-1:0]        rcnt, rcnt_nx;

   for (genvar i = 0; i < N_IN; i++) begin : g_flat
      assign w_flat[i*W_W +: W_W] = w[i];
   end

   // Writes land at the edge, so integration on that same edge still sees the old weight.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn)
         for (int i = 0; i < N_IN; i++) w[i] <= W_W'(W_INIT);
      else if (w_we && int'(w_addr) < N_IN)
         w[w_addr] <= w_data;

   snn_weighted_sum #(.N_IN(N_IN), .W_W(W_W), .SW(SW)) u_sum (
      .spike_in (spike_in),
      .w        (w_flat),
      .sum      (sum)
   );

   // Wide signed arithmetic: potential + sum - leak cannot wrap before the compares.
   assign vn     = VW'($signed({1'b0, v_mem})) + VW'(sum) - VW'($signed({1'b0, cfg_leak}));
   assign th_s   = VW'($signed({1'b0, cfg_thresh}));
   assign rest_s = VW'($signed({1'b0, cfg_rest}));

   always_comb begin
      state_nx = state;
      v_nx     = v_mem;
      spk_nx   = 1'b0;
      rcnt_nx  = rcnt;
      if (en) begin
         if (state == ST_INTEG) begin
            if (vn >= th_s) begin
               v_nx   = cfg_rest;
               spk_nx = 1'b1;
               if (REFRACT_CYC > 0) begin
                  state_nx = ST_REFRACT;
                  rcnt_nx  = RW'(REFRACT_CYC);
               end
            end else begin
               v_nx = (vn < rest_s) ? cfg_rest : V_W'(vn);
            end
         end else begin
            v_nx    = cfg_rest;
            rcnt_nx = rcnt - RW'(1);
            if (rcnt == RW'(1)) state_nx = ST_INTEG;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state     <= ST_INTEG;
         v_mem     <= '0;
         spike_out <= 1'b0;
         rcnt      <= '0;
      end else begin
         state     <= state_nx;
         v_mem     <= v_nx;
         spike_out <= spk_nx;
         rcnt      <= rcnt_nx;
      end

   // Counts on the edge that raises spike_out so the count and pulse appear together.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn)
         spike_cnt <= '0;
      else if (cnt_clr)
         spike_cnt <= '0;
      else if (spk_nx && !(&spike_cnt))
         spike_cnt <= spike_cnt + CNT_W'(1);

   assign refract = (state == ST_REFRACT);
endmodule

// File: tb/tb_lif_neuron_param.sv
// tb_lif_neuron_param: scoreboard bench for lif_neuron_param with two instances (no refractory / refractory+2-bit counter).
module tb_lif_neuron_param;
   logic       clk = 1'b0, resetn = 1'b0, en = 1'b0, w_we = 1'b0, cnt_clr = 1'b0;
   logic [2:0] spike_in = '0;
   logic [4:0] cfg_thresh = 5'd14, cfg_rest = 5'd6, cfg_leak = 5'd1;
   logic [1:0] w_addr = '0;
   logic [3:0] w_data = '0;
   logic       a_spk, a_rf, b_spk, b_rf;
   logic [4:0] a_v, b_v;
   logic [15:0] a_cnt;
   logic [1:0] b_cnt;

   typedef struct {
      int    id;
      int    cyc;
      int    v;
      int    s;
      int    r;
      int    c;
      string nm;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int n_chk = 0, n_fail = 0, ncyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ncyc++;

   lif_neuron_param #(.N_IN(3), .V_W(5), .W_W(4), .W_INIT(1), .REFRACT_CYC(0), .CNT_W(16)) dut_a (
      .clk(clk), .resetn(resetn), .en(en), .spike_in(spike_in),
      .cfg_thresh(cfg_thresh), .cfg_rest(cfg_rest), .cfg_leak(cfg_leak),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .cnt_clr(cnt_clr),
      .spike_out(a_spk), .v_mem(a_v), .refract(a_rf), .spike_cnt(a_cnt));

   lif_neuron_param #(.N_IN(3), .V_W(5), .W_W(4), .W_INIT(1), .REFRACT_CYC(3), .CNT_W(2)) dut_b (
      .clk(clk), .resetn(resetn), .en(en), .spike_in(spike_in),
      .cfg_thresh(cfg_thresh), .cfg_rest(cfg_rest), .cfg_leak(cfg_leak),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .cnt_clr(cnt_clr),
      .spike_out(b_spk), .v_mem(b_v), .refract(b_rf), .spike_cnt(b_cnt));

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   always @(negedge clk)
      while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
         e = sb.pop_front();
         if (e.cyc < ncyc) chk({e.nm, " late"}, ncyc, e.cyc);
         else begin
            chk({e.nm, " v_mem"},     e.id ? int'(b_v)   : int'(a_v),   e.v);
            chk({e.nm, " spike_out"}, e.id ? int'(b_spk) : int'(a_spk), e.s);
            chk({e.nm, " refract"},   e.id ? int'(b_rf)  : int'(a_rf),  e.r);
            chk({e.nm, " spike_cnt"}, e.id ? int'(b_cnt) : int'(a_cnt), e.c);
         end
      end

   task automatic tick(input logic [2:0] sp);
      @(negedge clk);
      w_we     = 1'b0;
      cnt_clr  = 1'b0;
      spike_in = sp;
   endtask

   task automatic ex(input int id, input int v, input int s, input int r, input int c, input string nm);
      exp_t x;
      x.id = id; x.cyc = ncyc + 1; x.v = v; x.s = s; x.r = r; x.c = c; x.nm = nm;
      sb.push_back(x);
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] d);
      w_we = 1'b1; w_addr = a; w_data = d;
   endtask

   task automatic do_reset;
      @(negedge clk);
      resetn = 1'b0; en = 1'b0; w_we = 1'b0; cnt_clr = 1'b0; spike_in = '0;
      #1 resetn = 1'b1;
   endtask

   initial begin
      int t1v[4];
      int c;
      t1v = '{6, 8, 10, 12};
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      tick(3'b000); ex(0, 0, 0, 0, 0, "rst_a"); ex(1, 0, 0, 0, 0, "rst_b");
      // T1: all weights 1, inputs held; clamp to rest then +2 per edge until threshold
      for (int i = 0; i < 4; i++) begin
         tick(3'b111); en = 1'b1; ex(0, t1v[i], 0, 0, 0, "t1_integ");
      end
      tick(3'b111); ex(0, 6, 1, 0, 1, "t1_fire");
      tick(3'b111); ex(0, 8, 0, 0, 1, "t1_after");
      tick(3'b111); en = 1'b0; ex(0, 8, 0, 0, 1, "t1_en0");
      tick(3'b111); ex(0, 8, 0, 0, 1, "t1_en0b");
      tick(3'b111); en = 1'b1; ex(0, 10, 0, 0, 1, "t1_en1");
      // T2: no input, leak alone holds the rest clamp
      do_reset;
      for (int i = 0; i < 20; i++) begin
         tick(3'b000); en = 1'b1; ex(0, 6, 0, 0, 0, "t2_idle");
      end
      // T3: weight writes, old weight on same edge, out-of-range address
      tick(3'b000); wr(2'd0, 4'hC); ex(0, 6, 0, 0, 0, "t3_wr");
      tick(3'b111); ex(0, 6, 0, 0, 0, "t3_neg");
      tick(3'b111); wr(2'd0, 4'h4); ex(0, 6, 0, 0, 0, "t3_old");
      tick(3'b111); ex(0, 11, 0, 0, 0, "t3_pos");
      tick(3'b111); ex(0, 6, 1, 0, 1, "t3_fire");
      tick(3'b111); wr(2'd3, 4'hC); ex(0, 11, 0, 0, 1, "t3_oob_wr");
      tick(3'b111); ex(0, 6, 1, 0, 2, "t3_oob");
      // T4: refractory instance
      do_reset;
      for (int i = 0; i < 4; i++) begin
         tick(3'b111); en = 1'b1; ex(1, t1v[i], 0, 0, 0, "t4_integ");
      end
      tick(3'b111); ex(1, 6, 1, 1, 1, "t4_fire");
      tick(3'b111); ex(1, 6, 0, 1, 1, "t4_ref1");
      tick(3'b111); ex(1, 6, 0, 1, 1, "t4_ref2");
      tick(3'b111); ex(1, 6, 0, 0, 1, "t4_ref3");
      tick(3'b111); ex(1, 8, 0, 0, 1, "t4_resume");
      tick(3'b111); ex(1, 10, 0, 0, 1, "t4_i10");
      tick(3'b111); ex(1, 12, 0, 0, 1, "t4_i12");
      tick(3'b111); ex(1, 6, 1, 1, 2, "t4_fire2");
      tick(3'b000); wr(2'd0, 4'hC); ex(1, 6, 0, 1, 2, "t4_wr");
      // T5: async reset mid-refractory, checked before any clock edge
      @(negedge clk);
      #1 resetn = 1'b0; en = 1'b0; w_we = 1'b0; spike_in = '0;
      #1;
      chk("t5 b_v_mem", int'(b_v), 0);
      chk("t5 b_refract", int'(b_rf), 0);
      chk("t5 b_spike_out", int'(b_spk), 0);
      chk("t5 b_spike_cnt", int'(b_cnt), 0);
      chk("t5 a_spike_cnt", int'(a_cnt), 0);
      resetn = 1'b1;
      tick(3'b111); en = 1'b1; ex(1, 6, 0, 0, 0, "t5_w1");
      tick(3'b111); ex(1, 8, 0, 0, 0, "t5_w2"); ex(0, 8, 0, 0, 0, "t5_w2a");
      // T6: heavy weight -> spike every refractory period; counter saturates at 3
      tick(3'b111); wr(2'd0, 4'h7); ex(1, 10, 0, 0, 0, "t6_wr");
      for (int k = 1; k <= 5; k++) begin
         c = (k > 3) ? 3 : k;
         tick(3'b111); ex(1, 6, 1, 1, c, "t6_fire");
         tick(3'b111); ex(1, 6, 0, 1, c, "t6_ref");
         tick(3'b111); ex(1, 6, 0, 1, c, "t6_ref");
         tick(3'b111); ex(1, 6, 0, 0, c, "t6_exit");
      end
      tick(3'b111); cnt_clr = 1'b1; ex(1, 6, 1, 1, 0, "t6_clr");
      tick(3'b111); ex(1, 6, 0, 1, 0, "t6_after_clr");
      repeat (2) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
